// File: rtl/mipi_csi_rx_raw_depacker_gearbox.sv
// rtl/mipi_csi_rx_raw_depacker_gearbox.sv - CSI-2 RAW8/10/12/14 byte-accumulating depacker; RAW14 enabled by MIPI_RAW_DEPACKER_RAW14_EN
module mipi_csi_rx_raw_depacker_gearbox #(
  parameter int LANES          = 4,
  parameter int BYTES_PER_LANE = 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  data_valid_i,
  input  logic [8*LANES*BYTES_PER_LANE-1:0]     data_i,
  input  logic [2:0]                            packet_type_i,
  output logic                                  output_valid_o,
  output logic [16*LANES*BYTES_PER_LANE-1:0]    output_o,
  output logic                                  raw_line_o,
  output logic                                  truncated_o,
  output logic                                  unsupported_o
);

  localparam int B      = LANES * BYTES_PER_LANE;
  localparam int NEED8  = B;
  localparam int NEED10 = 5 * B / 4;
  localparam int NEED12 = 3 * B / 2;
`ifdef MIPI_RAW_DEPACKER_RAW14_EN
  localparam int NEED14   = 7 * B / 4;
  localparam int NEED_MAX = NEED14;
`else
  localparam int NEED_MAX = NEED12;
`endif
  // Fill never reaches NEED, so one beat on top of a partial group always fits.
  localparam int BUF_BYTES = NEED_MAX + B;
  localparam int FW        = $clog2(BUF_BYTES + 1);
  localparam int BW        = 8 * BUF_BYTES;
  localparam int GW        = 8 * NEED_MAX;
  localparam int DW        = 8 * B;
  localparam int OW        = 16 * B;

  localparam logic [2:0] T_RAW8  = 3'd2;
  localparam logic [2:0] T_RAW10 = 3'd3;
  localparam logic [2:0] T_RAW12 = 3'd4;
  localparam logic [2:0] T_RAW14 = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERROR} state_t;

  state_t          state;
  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic            wait_low;
  logic [2:0]      mode;
  logic            mode_ok;
  logic [FW-1:0]   need;
  logic [FW-1:0]   fill;
  logic [FW-1:0]   fill_next;
  logic [FW-1:0]   tmp;
  logic [BW-1:0]   hold;
  logic [BW-1:0]   hold_next;
  logic [BW-1:0]   cat;
  logic [GW-1:0]   grp;
  logic [OW-1:0]   pix;
  logic            accept;
  logic            emit;

  assign raw_line_o = data_valid_i | (~reset_i & (r_valid | output_valid_o));

  // Stage R: register payload; a line cut short by reset is ignored until valid drops
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      wait_low <= data_valid_i;
      mode     <= T_RAW8;
    end else begin
      r_valid <= data_valid_i & ~wait_low;
      r_data  <= data_i;
      if (!data_valid_i) begin
        wait_low <= 1'b0;
      end
      if (data_valid_i && !r_valid && !wait_low) begin
        mode <= packet_type_i;
      end
    end
  end

  // Decode the latched mode into support flag and group size in bytes
  always_comb begin
    mode_ok = 1'b0;
    need    = FW'(NEED8);
    case (mode)
      T_RAW8: begin
        mode_ok = 1'b1;
        need    = FW'(NEED8);
      end
      T_RAW10: begin
        mode_ok = 1'b1;
        need    = FW'(NEED10);
      end
      T_RAW12: begin
        mode_ok = 1'b1;
        need    = FW'(NEED12);
      end
`ifdef MIPI_RAW_DEPACKER_RAW14_EN
      T_RAW14: begin
        mode_ok = 1'b1;
        need    = FW'(NEED14);
      end
`endif
      default: begin
        mode_ok = 1'b0;
        need    = FW'(NEED8);
      end
    endcase
  end

  // Gearbox: append the R beat above buffered bytes and peel off one group when enough are present
  always_comb begin
    accept    = r_valid & ((state == S_ACTIVE) | ((state == S_IDLE) & mode_ok));
    cat       = hold | (accept ? ({{(BW-DW){1'b0}}, r_data} << {fill, 3'b000}) : '0);
    tmp       = fill + (accept ? FW'(B) : '0);
    emit      = accept & (tmp >= need);
    grp       = cat[GW-1:0];
    hold_next = cat;
    fill_next = tmp;
    if (emit) begin
      hold_next = cat >> {need, 3'b000};
      fill_next = tmp - need;
    end
  end

  // Unpack the lowest group bytes into MSB-aligned 16-bit pixels
  always_comb begin
    pix = '0;
    case (mode)
      T_RAW8: begin
        for (int k = 0; k < B; k++) begin
          pix[16*k +: 16] = {grp[8*k +: 8], 8'h00};
        end
      end
      T_RAW10: begin
        for (int u = 0; u < B/4; u++) begin
          for (int k = 0; k < 4; k++) begin
            pix[16*(4*u+k) +: 16] = {grp[8*(5*u+k) +: 8], grp[8*(5*u+4)+2*k +: 2], 6'b000000};
          end
        end
      end
      T_RAW12: begin
        for (int v = 0; v < B/2; v++) begin
          pix[16*(2*v)   +: 16] = {grp[8*(3*v)   +: 8], grp[8*(3*v+2)   +: 4], 4'b0000};
          pix[16*(2*v+1) +: 16] = {grp[8*(3*v+1) +: 8], grp[8*(3*v+2)+4 +: 4], 4'b0000};
        end
      end
`ifdef MIPI_RAW_DEPACKER_RAW14_EN
      T_RAW14: begin
        for (int u = 0; u < B/4; u++) begin
          pix[16*(4*u)   +: 16] = {grp[8*(7*u)   +: 8], grp[8*(7*u+4) +: 6], 2'b00};
          pix[16*(4*u+1) +: 16] = {grp[8*(7*u+1) +: 8], grp[8*(7*u+5) +: 4],
                                   grp[8*(7*u+4)+6 +: 2], 2'b00};
          pix[16*(4*u+2) +: 16] = {grp[8*(7*u+2) +: 8], grp[8*(7*u+6) +: 2],
                                   grp[8*(7*u+5)+4 +: 4], 2'b00};
          pix[16*(4*u+3) +: 16] = {grp[8*(7*u+3) +: 8], grp[8*(7*u+6)+2 +: 6], 2'b00};
        end
      end
`endif
      default: pix = '0;
    endcase
  end

  // Line FSM with registered outputs, buffer update and end-of-line cleanup
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= S_IDLE;
      fill           <= '0;
      hold           <= '0;
      output_valid_o <= 1'b0;
      output_o       <= '0;
      truncated_o    <= 1'b0;
      unsupported_o  <= 1'b0;
    end else begin
      output_valid_o <= 1'b0;
      truncated_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (r_valid) begin
            if (mode_ok) begin
              state         <= S_ACTIVE;
              unsupported_o <= 1'b0;
            end else begin
              state         <= S_ERROR;
              unsupported_o <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (!r_valid) begin
            state       <= S_IDLE;
            truncated_o <= (fill != '0);
          end
        end
        S_ERROR: begin
          if (!r_valid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (accept) begin
        fill <= fill_next;
        hold <= hold_next;
        if (emit) begin
          output_valid_o <= 1'b1;
          output_o       <= pix;
        end
      end else if (!r_valid) begin
        fill <= '0;
        hold <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_gearbox.sv
// tb/tb_mipi_csi_rx_raw_depacker_gearbox.sv - scoreboard bench for the RAW depacker gearbox
module tb_mipi_csi_rx_raw_depacker_gearbox;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         data_valid_i;
  logic [63:0]  data_i;
  logic [2:0]   packet_type_i;
  logic         output_valid_o;
  logic [127:0] output_o;
  logic         raw_line_o;
  logic         truncated_o;
  logic         unsupported_o;

  mipi_csi_rx_raw_depacker_gearbox #(.LANES(4), .BYTES_PER_LANE(2)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .packet_type_i  (packet_type_i),
    .output_valid_o (output_valid_o),
    .output_o       (output_o),
    .raw_line_o     (raw_line_o),
    .truncated_o    (truncated_o),
    .unsupported_o  (unsupported_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           tq[$];
  logic [127:0] gq[$];
  logic [7:0]   bq[$];
  int           pass_cnt = 0;
  int           total_cnt = 0;

  localparam logic [127:0] G8A = {16'h0700, 16'h0600, 16'h0500, 16'h0400,
                                  16'h0300, 16'h0200, 16'h0100, 16'h0000};
  localparam logic [127:0] G8B = {16'h0F00, 16'h0E00, 16'h0D00, 16'h0C00,
                                  16'h0B00, 16'h0A00, 16'h0900, 16'h0800};
  localparam logic [127:0] G10 = {16'h0400, 16'h0340, 16'h0280, 16'h01C0,
                                  16'h55C0, 16'hAA80, 16'h0040, 16'hFF00};
  localparam logic [127:0] G12 = {16'hCD50, 16'hABF0, 16'h34B0, 16'h12A0,
                                  16'hCD50, 16'hABF0, 16'h34B0, 16'h12A0};
  localparam logic [127:0] G14 = {16'h446C, 16'h33A4, 16'h22AC, 16'h1114,
                                  16'h446C, 16'h33A4, 16'h22AC, 16'h1114};

  // Monitor: every presented group or truncation pulse must match the next expectation
  always @(negedge clk) begin
    exp_t e;
    int   tc;
    if (output_valid_o) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_group: got %h at cyc %0d, required no group", output_o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (output_o === e.data && cyc == e.cyc) pass_cnt++;
        else $display("FAIL group: got %h at cyc %0d, required %h at cyc %0d",
                      output_o, cyc, e.data, e.cyc);
      end
    end
    if (truncated_o) begin
      total_cnt++;
      if (tq.size() == 0) begin
        $display("FAIL unexpected_truncated: pulse at cyc %0d, required none", cyc);
      end else begin
        tc = tq.pop_front();
        if (cyc == tc) pass_cnt++;
        else $display("FAIL truncated: pulse at cyc %0d, required cyc %0d", cyc, tc);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  task automatic drive_beat(input logic [2:0] ptype, input bit produce);
    exp_t e;
    @(posedge clk);
    #1;
    data_valid_i  = 1'b1;
    packet_type_i = ptype;
    for (int j = 0; j < 8; j++) begin
      if (bq.size() != 0) data_i[8*j +: 8] = bq.pop_front();
      else data_i[8*j +: 8] = 8'h00;
    end
    if (produce && gq.size() != 0) begin
      e.data = gq.pop_front();
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  task automatic end_line(input bit trunc, input int idle);
    @(posedge clk);
    #1;
    data_valid_i = 1'b0;
    data_i       = '0;
    if (trunc) tq.push_back(cyc + 2);
    @(negedge clk);
    chk("raw_line_tail", {127'd0, raw_line_o}, 128'd1);
    repeat (idle) @(posedge clk);
  endtask

  task automatic send_line(input logic [2:0] ptype, input int n, input logic [7:0] mask,
                           input bit trunc, input int idle);
    for (int i = 0; i < n; i++) drive_beat(ptype, mask[i]);
    end_line(trunc, idle);
  endtask

  task automatic push_unit10a();
    bq.push_back(8'hFF); bq.push_back(8'h00); bq.push_back(8'hAA);
    bq.push_back(8'h55); bq.push_back(8'hE4);
  endtask

  task automatic push_unit10b();
    bq.push_back(8'h01); bq.push_back(8'h02); bq.push_back(8'h03);
    bq.push_back(8'h04); bq.push_back(8'h1B);
  endtask

  task automatic push_pair12();
    bq.push_back(8'h12); bq.push_back(8'h34); bq.push_back(8'hBA);
    bq.push_back(8'hAB); bq.push_back(8'hCD); bq.push_back(8'h5F);
  endtask

  task automatic push_unit14();
    bq.push_back(8'h11); bq.push_back(8'h22); bq.push_back(8'h33); bq.push_back(8'h44);
    bq.push_back(8'hC5); bq.push_back(8'h9A); bq.push_back(8'h6E);
  endtask

  initial begin
    reset_i       = 1'b1;
    data_valid_i  = 1'b0;
    data_i        = '0;
    packet_type_i = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid",       {127'd0, output_valid_o}, 128'd0);
    chk("reset_output",      output_o, 128'd0);
    chk("reset_truncated",   {127'd0, truncated_o}, 128'd0);
    chk("reset_unsupported", {127'd0, unsupported_o}, 128'd0);
    chk("reset_raw_line",    {127'd0, raw_line_o}, 128'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    // RAW8, two beats
    for (int i = 0; i < 16; i++) bq.push_back(8'(i));
    gq.push_back(G8A);
    gq.push_back(G8B);
    send_line(3'd2, 2, 8'b0000_0011, 1'b0, 4);
    @(negedge clk);
    chk("raw_line_idle", {127'd0, raw_line_o}, 128'd0);

    // RAW10, five beats, four groups
    for (int i = 0; i < 4; i++) begin
      push_unit10a();
      push_unit10b();
      gq.push_back(G10);
    end
    send_line(3'd3, 5, 8'b0001_1110, 1'b0, 4);

    // RAW12, three beats, two groups
    for (int i = 0; i < 4; i++) push_pair12();
    gq.push_back(G12);
    gq.push_back(G12);
    send_line(3'd4, 3, 8'b0000_0110, 1'b0, 4);

    // RAW14, seven beats
    for (int i = 0; i < 8; i++) push_unit14();
`ifdef MIPI_RAW_DEPACKER_RAW14_EN
    for (int i = 0; i < 4; i++) gq.push_back(G14);
    send_line(3'd5, 7, 8'b0110_1010, 1'b0, 2);
    chk("raw14_unsupported", {127'd0, unsupported_o}, 128'd0);
`else
    send_line(3'd5, 7, 8'b0000_0000, 1'b0, 2);
    chk("raw14_unsupported", {127'd0, unsupported_o}, 128'd1);
`endif

    // Unsupported type 7 stays flagged after the line ends
    for (int i = 0; i < 16; i++) bq.push_back(8'hA5);
    send_line(3'd7, 2, 8'b0000_0000, 1'b0, 3);
    @(negedge clk);
    chk("type7_unsupported", {127'd0, unsupported_o}, 128'd1);

    // RAW10 truncated line, then back-to-back full line after one idle cycle
    push_unit10a(); push_unit10b(); push_unit10a(); push_unit10b();
    bq.push_back(8'hDE); bq.push_back(8'hAD); bq.push_back(8'hBE); bq.push_back(8'hEF);
    gq.push_back(G10);
    gq.push_back(G10);
    send_line(3'd3, 3, 8'b0000_0110, 1'b1, 0);
    chk("unsupported_cleared", {127'd0, unsupported_o}, 128'd0);
    for (int i = 0; i < 4; i++) begin
      push_unit10a();
      push_unit10b();
      gq.push_back(G10);
    end
    send_line(3'd3, 5, 8'b0001_1110, 1'b0, 4);

    // Reset in the middle of a RAW12 line
    for (int i = 0; i < 6; i++) push_pair12();
    for (int i = 0; i < 4; i++) bq.push_back(8'h77);
    gq.push_back(G12);
    drive_beat(3'd4, 1'b0);
    drive_beat(3'd4, 1'b1);
    drive_beat(3'd4, 1'b0);
    drive_beat(3'd4, 1'b0);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("midreset_valid",     {127'd0, output_valid_o}, 128'd0);
    chk("midreset_output",    output_o, 128'd0);
    chk("midreset_truncated", {127'd0, truncated_o}, 128'd0);
    drive_beat(3'd4, 1'b0);
    @(posedge clk);
    #1;
    data_valid_i = 1'b0;
    data_i       = '0;
    repeat (3) @(posedge clk);

    // Clean RAW12 line after reset
    for (int i = 0; i < 4; i++) push_pair12();
    gq.push_back(G12);
    gq.push_back(G12);
    send_line(3'd4, 3, 8'b0000_0110, 1'b0, 5);

    @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0 && tq.size() == 0) pass_cnt++;
    else $display("FAIL pending: %0d groups and %0d truncations never seen, required 0 and 0",
                  exp_q.size(), tq.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
